// File: rtl/regfile_wb_sequencer.sv
// rtl/regfile_wb_sequencer.sv - Y86 write-back sequencer: queues decoded register writes, one per cycle.
// Optional WBSEQ_PERF_EN adds wr_count/full_count performance counters.
module regfile_wb_sequencer #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_icode,
   input  logic [3:0]        req_rA,
   input  logic [3:0]        req_rB,
   input  logic              req_cnd,
   input  logic [DATA_W-1:0] req_valE,
   input  logic [DATA_W-1:0] req_valM,
   output logic              wr_en,
   output logic [3:0]        wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [14:0]       busy_mask,
`ifdef WBSEQ_PERF_EN
   output logic [31:0]       wr_count,
   output logic [31:0]       full_count,
`endif
   output logic              idle
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] R_NONE = 4'hF;
   localparam logic [3:0] R_SP   = 4'h4;

   typedef enum logic [1:0] {S_IDLE, S_WR1, S_WR2} state_t;
   state_t state;

   logic [3:0]        q_a1 [DEPTH];
   logic [DATA_W-1:0] q_d1 [DEPTH];
   logic [3:0]        q_a2 [DEPTH];
   logic [DATA_W-1:0] q_d2 [DEPTH];
   logic              q_h2 [DEPTH];
   logic [AW-1:0]     head, tail, head_nx;
   logic [AW:0]       count, count_n;

   logic              c_v1, c_v2, k1, k2, n_has1, n_has2;
   logic [3:0]        c_a1, c_a2, n_a1;
   logic [DATA_W-1:0] c_d1, c_d2, n_d1;
   logic              push, pop;
   logic [3:0]        nh_a;
   logic [DATA_W-1:0] nh_d;

   // Raw write candidates per icode, then compacted so a surviving write is always slot 1.
   always_comb begin
      c_v1 = 1'b0; c_a1 = R_NONE; c_d1 = '0;
      c_v2 = 1'b0; c_a2 = R_NONE; c_d2 = '0;
      case (req_icode)
         4'h2:             begin c_v1 = req_cnd; c_a1 = req_rB; c_d1 = req_valE; end
         4'h3, 4'h6:       begin c_v1 = 1'b1;    c_a1 = req_rB; c_d1 = req_valE; end
         4'h5:             begin c_v1 = 1'b1;    c_a1 = req_rA; c_d1 = req_valM; end
         4'h8, 4'h9, 4'hA: begin c_v1 = 1'b1;    c_a1 = R_SP;   c_d1 = req_valE; end
         4'hB: begin
            c_v1 = 1'b1; c_a1 = R_SP;   c_d1 = req_valE;
            c_v2 = 1'b1; c_a2 = req_rA; c_d2 = req_valM;
         end
         default: ;
      endcase
      k1     = c_v1 && (c_a1 != R_NONE);
      k2     = c_v2 && (c_a2 != R_NONE);
      n_has1 = k1 || k2;
      n_has2 = k1 && k2;
      n_a1   = k1 ? c_a1 : c_a2;
      n_d1   = k1 ? c_d1 : c_d2;
   end

   assign req_ready = reset && (count < (AW+1)'(DEPTH));
   assign push      = req_valid && req_ready && n_has1;
   assign pop       = ((state == S_WR1) && !q_h2[head]) || (state == S_WR2);
   assign head_nx   = head + AW'(1);
   assign count_n   = count + (AW+1)'(push) - (AW+1)'(pop);
   assign idle      = (state == S_IDLE) && (count == '0);

   // First write of whichever entry will be at the head after this edge.
   always_comb begin
      nh_a = n_a1;
      nh_d = n_d1;
      if (pop && (count > (AW+1)'(1))) begin
         nh_a = q_a1[head_nx];
         nh_d = q_d1[head_nx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
      end else begin
         if (push) tail <= tail + AW'(1);
         if (pop)  head <= head_nx;
         count <= count_n;
         if ((state == S_WR1) && q_h2[head]) begin
            state   <= S_WR2;
            wr_en   <= 1'b1;
            wr_addr <= q_a2[head];
            wr_data <= q_d2[head];
         end else if (count_n != '0) begin
            state   <= S_WR1;
            wr_en   <= 1'b1;
            wr_addr <= nh_a;
            wr_data <= nh_d;
         end else begin
            state <= S_IDLE;
            wr_en <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_a1[tail] <= n_a1;
         q_d1[tail] <= n_d1;
         q_a2[tail] <= c_a2;
         q_d2[tail] <= c_d2;
         q_h2[tail] <= n_has2;
      end
   end

   // The head's first target is already retired once its second write is on the port.
   always_comb begin
      logic [15:0]   m;
      logic [AW-1:0] idx;
      m   = '0;
      idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + AW'(k);
         if ((AW+1)'(k) < count) begin
            if (!((k == 0) && (state == S_WR2))) m[q_a1[idx]] = 1'b1;
            if (q_h2[idx]) m[q_a2[idx]] = 1'b1;
         end
      end
      busy_mask = m[14:0];
   end

`ifdef WBSEQ_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_count   <= '0;
         full_count <= '0;
      end else begin
         if (wr_en) wr_count <= wr_count + 32'd1;
         if (req_valid && !req_ready) full_count <= full_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// tb/tb_regfile_wb_sequencer.sv - Directed vector bench for regfile_wb_sequencer.
module tb_regfile_wb_sequencer;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [3:0]    req_icode = '0, req_rA = '0, req_rB = '0;
   logic          req_cnd = 1'b0;
   logic [DW-1:0] req_valE = '0, req_valM = '0;
   logic          wr_en;
   logic [3:0]    wr_addr;
   logic [DW-1:0] wr_data;
   logic [14:0]   busy_mask;
   logic          idle;
`ifdef WBSEQ_PERF_EN
   logic [31:0]   wr_count, full_count;
`endif

   regfile_wb_sequencer #(.DATA_W(DW), .DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_icode(req_icode), .req_rA(req_rA), .req_rB(req_rB), .req_cnd(req_cnd),
      .req_valE(req_valE), .req_valM(req_valM),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy_mask(busy_mask),
`ifdef WBSEQ_PERF_EN
      .wr_count(wr_count), .full_count(full_count),
`endif
      .idle(idle)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   typedef struct {
      logic [3:0]  icode, ra, rb;
      logic        cnd;
      logic [63:0] vale, valm;
      int          n;
      logic [3:0]  a1;
      logic [63:0] d1;
      logic [3:0]  a2;
      logic [63:0] d2;
      logic [14:0] b1, b2;
      string       name;
   } vec_t;

   vec_t vt[13];

   task automatic set_req(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                          input logic cnd, input logic [63:0] ve, input logic [63:0] vm);
      req_icode = ic; req_rA = ra; req_rB = rb; req_cnd = cnd; req_valE = ve; req_valM = vm;
   endtask

   initial begin
      int          acc_edge[3];
      int          nacc;
      int          nwr, run, max_run;
      logic        acc, seen;
      logic        rdy_after[13];
      logic [3:0]  wa[6];
      logic [63:0] wd[6];
      logic [3:0]  exp_a[6];
      logic [63:0] exp_d[6];

      vt[0]  = '{4'h3, 4'hF, 4'h3, 1'b0, 64'h55,   64'h0,   1, 4'h3, 64'h55,   4'h0, 64'h0,   15'h0008, 15'h0000, "irmovq_r3"};
      vt[1]  = '{4'h2, 4'hF, 4'h5, 1'b0, 64'h7,    64'h0,   0, 4'h0, 64'h0,    4'h0, 64'h0,   15'h0000, 15'h0000, "cmov_nc"};
      vt[2]  = '{4'h2, 4'hF, 4'h5, 1'b1, 64'h7,    64'h0,   1, 4'h5, 64'h7,    4'h0, 64'h0,   15'h0020, 15'h0000, "cmov_c"};
      vt[3]  = '{4'hB, 4'h2, 4'hF, 1'b0, 64'h100,  64'hAB,  2, 4'h4, 64'h100,  4'h2, 64'hAB,  15'h0014, 15'h0004, "popq_r2"};
      vt[4]  = '{4'hB, 4'h4, 4'hF, 1'b0, 64'h200,  64'h300, 2, 4'h4, 64'h200,  4'h4, 64'h300, 15'h0010, 15'h0010, "popq_r4"};
      vt[5]  = '{4'h5, 4'h7, 4'h1, 1'b0, 64'h999,  64'h77,  1, 4'h7, 64'h77,   4'h0, 64'h0,   15'h0080, 15'h0000, "mrmovq"};
      vt[6]  = '{4'h6, 4'h1, 4'hE, 1'b0, 64'h9,    64'h0,   1, 4'hE, 64'h9,    4'h0, 64'h0,   15'h4000, 15'h0000, "opq_r14"};
      vt[7]  = '{4'h3, 4'hF, 4'hF, 1'b0, 64'h5,    64'h0,   0, 4'h0, 64'h0,    4'h0, 64'h0,   15'h0000, 15'h0000, "irmovq_none"};
      vt[8]  = '{4'h8, 4'hF, 4'hF, 1'b0, 64'h1F0,  64'h0,   1, 4'h4, 64'h1F0,  4'h0, 64'h0,   15'h0010, 15'h0000, "call"};
      vt[9]  = '{4'hB, 4'hF, 4'hF, 1'b0, 64'h3F8,  64'hAA,  1, 4'h4, 64'h3F8,  4'h0, 64'h0,   15'h0010, 15'h0000, "popq_none"};
      vt[10] = '{4'h1, 4'h3, 4'h3, 1'b1, 64'h11,   64'h22,  0, 4'h0, 64'h0,    4'h0, 64'h0,   15'h0000, 15'h0000, "nop"};
      vt[11] = '{4'h6, 4'h2, 4'h0, 1'b0, 64'hDEAD, 64'h0,   1, 4'h0, 64'hDEAD, 4'h0, 64'h0,   15'h0001, 15'h0000, "opq_r0"};
      vt[12] = '{4'hA, 4'h3, 4'h4, 1'b0, 64'h1E8,  64'h5,   1, 4'h4, 64'h1E8,  4'h0, 64'h0,   15'h0010, 15'h0000, "pushq"};

      // Reset state
      #1;
      check("rst.req_ready", req_ready, 0);
      check("rst.wr_en", wr_en, 0);
      check("rst.busy_mask", busy_mask, 0);
      check("rst.idle", idle, 1);
      check("rst.wr_addr", wr_addr, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel.req_ready", req_ready, 1);
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         set_req(vt[i].icode, vt[i].ra, vt[i].rb, vt[i].cnd, vt[i].vale, vt[i].valm);
         req_valid = 1'b1;
         @(posedge clk); #1;
         req_valid = 1'b0;
         if (vt[i].n == 0) begin
            check({vt[i].name, ".wr_en"}, wr_en, 0);
            check({vt[i].name, ".busy"}, busy_mask, 0);
            check({vt[i].name, ".idle"}, idle, 1);
         end else begin
            check({vt[i].name, ".w1_en"}, wr_en, 1);
            check({vt[i].name, ".w1_addr"}, wr_addr, vt[i].a1);
            check({vt[i].name, ".w1_data"}, wr_data, vt[i].d1);
            check({vt[i].name, ".w1_busy"}, busy_mask, vt[i].b1);
            check({vt[i].name, ".w1_idle"}, idle, 0);
            @(posedge clk); #1;
            if (vt[i].n == 2) begin
               check({vt[i].name, ".w2_en"}, wr_en, 1);
               check({vt[i].name, ".w2_addr"}, wr_addr, vt[i].a2);
               check({vt[i].name, ".w2_data"}, wr_data, vt[i].d2);
               check({vt[i].name, ".w2_busy"}, busy_mask, vt[i].b2);
               @(posedge clk); #1;
            end
            check({vt[i].name, ".end_en"}, wr_en, 0);
            check({vt[i].name, ".end_busy"}, busy_mask, 0);
            check({vt[i].name, ".end_idle"}, idle, 1);
         end
      end

      // Three back-to-back popq requests held valid against a 2-entry queue
      exp_a = '{4'h4, 4'h1, 4'h4, 4'h2, 4'h4, 4'h3};
      exp_d = '{64'h10, 64'h11, 64'h20, 64'h21, 64'h30, 64'h31};
      nacc = 0; nwr = 0; run = 0; max_run = 0;
      set_req(4'hB, 4'h1, 4'hF, 1'b0, 64'h10, 64'h11);
      req_valid = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         acc = req_valid && req_ready;
         @(posedge clk); #1;
         rdy_after[e] = req_ready;
         if (acc) begin
            if (nacc < 3) acc_edge[nacc] = e;
            nacc++;
            if (nacc == 1)      set_req(4'hB, 4'h2, 4'hF, 1'b0, 64'h20, 64'h21);
            else if (nacc == 2) set_req(4'hB, 4'h3, 4'hF, 1'b0, 64'h30, 64'h31);
            else                req_valid = 1'b0;
         end
         if (wr_en) begin
            if (nwr < 6) begin wa[nwr] = wr_addr; wd[nwr] = wr_data; end
            nwr++; run++;
            if (run > max_run) max_run = run;
         end else run = 0;
      end
      req_valid = 1'b0;
      check("b2b.n_accepted", nacc, 3);
      check("b2b.acc0_edge", acc_edge[0], 1);
      check("b2b.acc1_edge", acc_edge[1], 2);
      check("b2b.acc2_edge", acc_edge[2], 4);
      check("b2b.ready_full", rdy_after[2], 0);
      check("b2b.ready_rise", rdy_after[3], 1);
      check("b2b.n_writes", nwr, 6);
      check("b2b.run_len", max_run, 6);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("b2b.w%0d_addr", k), wa[k], exp_a[k]);
         check($sformatf("b2b.w%0d_data", k), wd[k], exp_d[k]);
      end
      check("b2b.idle", idle, 1);

      // Reset during the second write of a popq
      set_req(4'hB, 4'h6, 4'hF, 1'b0, 64'h60, 64'h61);
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("rmid.w1_addr", wr_addr, 4'h4);
      @(posedge clk); #1;
      check("rmid.w2_en", wr_en, 1);
      check("rmid.w2_addr", wr_addr, 4'h6);
      check("rmid.w2_busy", busy_mask, 15'h0040);
      #2 reset = 1'b0;
      #1;
      check("rmid.wr_en", wr_en, 0);
      check("rmid.busy", busy_mask, 0);
      check("rmid.req_ready", req_ready, 0);
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         seen |= wr_en;
      end
      check("rmid.no_replay", seen, 0);
      check("rmid.idle", idle, 1);
      check("rmid.ready", req_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
